// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors match engine: judges rounds, keeps saturating scores and drives a 4-digit display.
// Optional build macro RPS_LFSR_CPU_EN replaces the compu input with an on-chip 8-bit LFSR move source.
module rps_match_scorer #(
  parameter int SCORE_W    = 7,
  parameter int WIN_TARGET = 5,
  parameter int SCAN_DIV   = 250000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               play,
  input  logic               clear,
  input  logic [2:0]         user,
  input  logic [2:0]         compu,
  output logic [1:0]         winornot,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic               match_over,
  output logic [1:0]         champion,
  output logic [6:0]         seg,
  output logic [3:0]         COM
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, JUDGE, OVER} state_t;

  state_t state, state_nxt;

  logic       play_q, round_req;
  logic [2:0] move_u, move_c, cpu_pick;
  logic [3:0] u_ones, u_tens, c_ones, c_tens;
  logic       valid_u, valid_c, user_wins, cpu_wins;
  logic       user_inc, cpu_inc, reach;
  logic [1:0] result;

  assign round_req = play & ~play_q;

`ifdef RPS_LFSR_CPU_EN
  logic [7:0] lfsr;
  logic       unused_compu;

  assign unused_compu = ^compu;

  always_ff @(posedge CLK) begin
    if (!RST_N) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_comb begin
    case (lfsr % 8'd3)
      8'd0:    cpu_pick = 3'b001;
      8'd1:    cpu_pick = 3'b010;
      default: cpu_pick = 3'b100;
    endcase
  end
`else
  assign cpu_pick = compu;
`endif

  function automatic logic onehot3(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    return (a == 3'b001 && b == 3'b100) ||
           (a == 3'b100 && b == 3'b010) ||
           (a == 3'b010 && b == 3'b001);
  endfunction

  always_comb begin
    valid_u   = onehot3(move_u);
    valid_c   = onehot3(move_c);
    user_wins = valid_u && valid_c && beats(move_u, move_c);
    cpu_wins  = valid_u && valid_c && beats(move_c, move_u);
    if (!(valid_u && valid_c)) result = 2'b11;
    else if (user_wins)        result = 2'b10;
    else if (cpu_wins)         result = 2'b01;
    else                       result = 2'b00;
    user_inc = user_wins && (user_score < SCORE_W'(WIN_TARGET));
    cpu_inc  = cpu_wins  && (cpu_score  < SCORE_W'(WIN_TARGET));
    reach    = (user_inc && user_score == SCORE_W'(WIN_TARGET - 1)) ||
               (cpu_inc  && cpu_score  == SCORE_W'(WIN_TARGET - 1));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // clear overrides everything, including a round request in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (round_req) state_nxt = JUDGE;
      JUDGE:   state_nxt = reach ? OVER : IDLE;
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  assign match_over = (state == OVER);

  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    else              return {tens, ones + 4'd1};
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      play_q     <= 1'b0;
      move_u     <= 3'b000;
      move_c     <= 3'b000;
      winornot   <= 2'b00;
      user_score <= '0;
      cpu_score  <= '0;
      u_ones     <= 4'd0;
      u_tens     <= 4'd0;
      c_ones     <= 4'd0;
      c_tens     <= 4'd0;
      champion   <= 2'b00;
    end else begin
      play_q <= play;
      if (clear) begin
        winornot   <= 2'b00;
        user_score <= '0;
        cpu_score  <= '0;
        u_ones     <= 4'd0;
        u_tens     <= 4'd0;
        c_ones     <= 4'd0;
        c_tens     <= 4'd0;
        champion   <= 2'b00;
      end else if (state == IDLE && round_req) begin
        move_u <= user;
        move_c <= cpu_pick;
      end else if (state == JUDGE) begin
        winornot <= result;
        if (user_inc) begin
          user_score       <= user_score + SCORE_W'(1);
          {u_tens, u_ones} <= bcd_inc(u_tens, u_ones);
        end
        if (cpu_inc) begin
          cpu_score        <= cpu_score + SCORE_W'(1);
          {c_tens, c_ones} <= bcd_inc(c_tens, c_ones);
        end
        if (reach) champion <= user_inc ? 2'b10 : 2'b01;
      end
    end
  end

  logic [DIV_W-1:0] div;
  logic [1:0]       slot, slot_nxt;
  logic [3:0]       digit;
  logic             blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // seg is looked up for the slot being entered so it changes on the same edge as COM
  always_comb begin
    slot_nxt = slot - 2'd1;
    digit    = 4'd0;
    blank    = 1'b0;
    case (slot_nxt)
      2'd3: begin digit = u_tens; blank = (u_tens == 4'd0); end
      2'd2: digit = u_ones;
      2'd1: begin digit = c_tens; blank = (c_tens == 4'd0); end
      default: digit = c_ones;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div  <= '0;
      slot <= 2'd3;
      COM  <= 4'b0111;
      seg  <= 7'b0000001;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div  <= '0;
      slot <= slot_nxt;
      COM  <= ~(4'b0001 << slot_nxt);
      seg  <= blank ? 7'b1111111 : glyph(digit);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed bench for rps_match_scorer: instance a (target 5) and b (target 12) share stimulus.
// Build with RPS_LFSR_CPU_EN defined to run the LFSR move-source checks instead of the compu tests.
module tb_rps_match_scorer;

  logic       CLK = 1'b0;
  logic       RST_N, play, clear;
  logic [2:0] user, compu;

  logic [1:0] a_win, b_win, a_champ, b_champ;
  logic [6:0] a_us, a_cs, b_us, b_cs, a_seg, b_seg;
  logic       a_over, b_over;
  logic [3:0] a_com, b_com;

  int checks = 0;
  int errors = 0;

  rps_match_scorer #(.SCORE_W(7), .WIN_TARGET(5), .SCAN_DIV(4)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .play(play), .clear(clear), .user(user), .compu(compu),
    .winornot(a_win), .user_score(a_us), .cpu_score(a_cs), .match_over(a_over),
    .champion(a_champ), .seg(a_seg), .COM(a_com));

  rps_match_scorer #(.SCORE_W(7), .WIN_TARGET(12), .SCAN_DIV(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .play(play), .clear(clear), .user(user), .compu(compu),
    .winornot(b_win), .user_score(b_us), .cpu_score(b_cs), .match_over(b_over),
    .champion(b_champ), .seg(b_seg), .COM(b_com));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_round(input logic [2:0] u, input logic [2:0] c);
    user  = u;
    compu = c;
    play  = 1'b1;
    tick(2);
  endtask

  task automatic end_round();
    play = 1'b0;
    tick(1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  typedef struct {
    logic [2:0] u;
    logic [2:0] c;
    logic [1:0] win;
    int         us;
    int         cs;
  } vec_t;

  vec_t vecs[9];

`ifdef RPS_LFSR_CPU_EN
  logic [7:0] lfsr_m;
  always @(posedge CLK) begin
    if (!RST_N) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end
`endif

  initial begin
    logic [3:0] com_exp[4];
    logic [6:0] bseg_exp[4];
    logic [6:0] aseg_exp[4];

    vecs[0] = '{3'b010, 3'b001, 2'b10, 1, 0};
    vecs[1] = '{3'b011, 3'b001, 2'b11, 1, 0};
    vecs[2] = '{3'b100, 3'b100, 2'b00, 1, 0};
    vecs[3] = '{3'b001, 3'b100, 2'b10, 2, 0};
    vecs[4] = '{3'b100, 3'b001, 2'b01, 2, 1};
    vecs[5] = '{3'b000, 3'b010, 2'b11, 2, 1};
    vecs[6] = '{3'b010, 3'b100, 2'b01, 2, 2};
    vecs[7] = '{3'b001, 3'b001, 2'b00, 2, 2};
    vecs[8] = '{3'b100, 3'b010, 2'b10, 3, 2};

    com_exp  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    bseg_exp = '{7'b1001111, 7'b0010010, 7'b1111111, 7'b0000001};
    aseg_exp = '{7'b1111111, 7'b0100100, 7'b1111111, 7'b0000001};

    RST_N = 1'b0; play = 1'b0; clear = 1'b0; user = 3'b000; compu = 3'b000;
    tick(2);
    check("rst_user_score", a_us, 0);
    check("rst_cpu_score", a_cs, 0);
    check("rst_winornot", a_win, 0);
    check("rst_com", a_com, 4'b0111);
    check("rst_seg", a_seg, 7'b0000001);
    check("rst_match_over", a_over, 0);
    check("rst_champion", a_champ, 0);
    check("rst_b_com", b_com, 4'b0111);
    RST_N = 1'b1;
    tick(1);

`ifdef RPS_LFSR_CPU_EN
    for (int i = 0; i < 30; i++) begin
      logic [1:0] exp_win;
      do_clear();
      case (lfsr_m % 8'd3)
        8'd0:    exp_win = 2'b00;
        8'd1:    exp_win = 2'b01;
        default: exp_win = 2'b10;
      endcase
      user = 3'b001;
      play = 1'b1;
      tick(2);
      check($sformatf("lfsr_round_%0d", i), b_win, exp_win);
      end_round();
    end
`else
    // reset while the round is in JUDGE must discard it
    user = 3'b010; compu = 3'b001; play = 1'b1;
    tick(1);
    RST_N = 1'b0; play = 1'b0;
    tick(1);
    RST_N = 1'b1;
    tick(2);
    check("midrst_user_score", b_us, 0);
    check("midrst_winornot", b_win, 0);

    start_round(3'b010, 3'b001);
    check("t2_winornot", b_win, 2'b10);
    check("t2_user_score", b_us, 1);
    check("t2_cpu_score", b_cs, 0);
    user = 3'b001; compu = 3'b010;
    tick(20);
    check("hold_winornot", b_win, 2'b10);
    check("hold_user_score", b_us, 1);
    check("hold_cpu_score", b_cs, 0);
    end_round();
    do_clear();
    check("clear_user_score", b_us, 0);
    check("clear_winornot", b_win, 0);

    for (int i = 0; i < 9; i++) begin
      start_round(vecs[i].u, vecs[i].c);
      check($sformatf("vec%0d_a_win", i), a_win, vecs[i].win);
      check($sformatf("vec%0d_a_us", i), a_us, vecs[i].us);
      check($sformatf("vec%0d_a_cs", i), a_cs, vecs[i].cs);
      check($sformatf("vec%0d_b_win", i), b_win, vecs[i].win);
      check($sformatf("vec%0d_b_us", i), b_us, vecs[i].us);
      check($sformatf("vec%0d_b_cs", i), b_cs, vecs[i].cs);
      end_round();
    end
    do_clear();

    for (int i = 0; i < 5; i++) begin
      start_round(3'b001, 3'b010);
      check($sformatf("t4_a_cs_%0d", i), a_cs, i + 1);
      check($sformatf("t4_b_cs_%0d", i), b_cs, i + 1);
      end_round();
    end
    check("t4_a_over", a_over, 1);
    check("t4_a_champion", a_champ, 2'b01);
    check("t4_b_over", b_over, 0);
    check("t4_b_champion", b_champ, 2'b00);
    start_round(3'b010, 3'b001);
    check("t4_over_win_held", a_win, 2'b01);
    check("t4_over_us_held", a_us, 0);
    check("t4_over_cs_held", a_cs, 5);
    check("t4_b_win", b_win, 2'b10);
    check("t4_b_us", b_us, 1);
    end_round();
    do_clear();
    check("t4_clear_over", a_over, 0);
    check("t4_clear_champion", a_champ, 0);
    check("t4_clear_cs", a_cs, 0);
    check("t4_clear_b_us", b_us, 0);

    for (int i = 0; i < 12; i++) begin
      start_round(3'b010, 3'b001);
      end_round();
    end
    check("t5_b_us", b_us, 12);
    check("t5_b_over", b_over, 1);
    check("t5_b_champion", b_champ, 2'b10);
    check("t5_a_us_sat", a_us, 5);
    check("t5_a_champion", a_champ, 2'b10);

    tick(8);
    begin
      int k = 0;
      while (b_com !== 4'b0111 && k < 16) begin
        tick(1);
        k++;
      end
    end
    for (int s = 0; s < 4; s++) begin
      check($sformatf("scan%0d_b_com", s), b_com, com_exp[s]);
      check($sformatf("scan%0d_b_seg", s), b_seg, bseg_exp[s]);
      check($sformatf("scan%0d_a_com", s), a_com, com_exp[s]);
      check($sformatf("scan%0d_a_seg", s), a_seg, aseg_exp[s]);
      tick(4);
    end

    user = 3'b010; compu = 3'b001;
    clear = 1'b1; play = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    check("clrplay_over_b_us", b_us, 0);
    check("clrplay_over_b_win", b_win, 0);
    check("clrplay_over_b_over", b_over, 0);
    check("clrplay_over_a_us", a_us, 0);
    play = 1'b0;
    tick(1);

    clear = 1'b1; play = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    check("clrplay_idle_b_us", b_us, 0);
    check("clrplay_idle_b_cs", b_cs, 0);
    check("clrplay_idle_b_win", b_win, 0);
    play = 1'b0;
    tick(1);

    start_round(3'b100, 3'b010);
    check("final_b_win", b_win, 2'b10);
    check("final_b_us", b_us, 1);
    end_round();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
